// File: rtl/raster_timing_gen.sv
// rtl/raster_timing_gen.sv - runtime-programmable raster timing generator
//
// Purpose:
//   Signed x/y raster counters that advance on a pixel-clock enable. The
//   outputs are active video, hsync/vsync and line/frame end strobes, all
//   decoded combinationally from the counters and the eight timing
//   registers. The registers can be written at runtime.
//
// Optional feature (macro RASTER_SHADOW_EN):
//   When defined, register writes go to shadow copies. The shadows load into
//   the active registers on the frame_end edge, so timing never changes
//   mid-frame. When undefined, writes update the active registers directly.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   enable                pixel-clock enable
//   cfg_we/cfg_sel/cfg_data
//                         register write; sel 0..3 = x0,x_fp,x_s,x1 and
//                         4..7 = y0,y_fp,y_s,y1
//   x, y                  signed current column / row
//   active, hsync, vsync  video decodes
//   line_end, frame_end   strobes, qualified by enable
module raster_timing_gen #(
  parameter int X_BITS    = 11,
  parameter int Y_BITS    = 10,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int RST_X0    = -48,
  parameter int RST_X_FP  = 640,
  parameter int RST_X_S   = 656,
  parameter int RST_X1    = 752,
  parameter int RST_Y0    = -33,
  parameter int RST_Y_FP  = 480,
  parameter int RST_Y_S   = 490,
  parameter int RST_Y1    = 492
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_sel,
  input  logic [X_BITS-1:0]        cfg_data,
  output logic signed [X_BITS-1:0] x,
  output logic signed [Y_BITS-1:0] y,
  output logic                     active,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     line_end,
  output logic                     frame_end
);

  typedef logic signed [X_BITS-1:0] xval_t;
  typedef logic signed [Y_BITS-1:0] yval_t;

  localparam xval_t R_X0   = xval_t'(RST_X0);
  localparam xval_t R_X_FP = xval_t'(RST_X_FP);
  localparam xval_t R_X_S  = xval_t'(RST_X_S);
  localparam xval_t R_X1   = xval_t'(RST_X1);
  localparam yval_t R_Y0   = yval_t'(RST_Y0);
  localparam yval_t R_Y_FP = yval_t'(RST_Y_FP);
  localparam yval_t R_Y_S  = yval_t'(RST_Y_S);
  localparam yval_t R_Y1   = yval_t'(RST_Y1);
  localparam xval_t X_ONE  = xval_t'(1);
  localparam yval_t Y_ONE  = yval_t'(1);

  // Active timing registers; all output decodes use these.
  xval_t x0, x_fp, x_s, x1;
  yval_t y0, y_fp, y_s, y1;

  // Register image with this cycle's write merged in. In shadow mode the
  // merge starts from the shadows. The active registers then take this
  // image at frame_end, so a write in the frame_end cycle lands on that
  // same edge.
  xval_t x0_w, x_fp_w, x_s_w, x1_w;
  yval_t y0_w, y_fp_w, y_s_w, y1_w;

  logic last_x, last_y;

`ifdef RASTER_SHADOW_EN
  xval_t x0_sh, x_fp_sh, x_s_sh, x1_sh;
  yval_t y0_sh, y_fp_sh, y_s_sh, y1_sh;
`endif

  always_comb begin
`ifdef RASTER_SHADOW_EN
    x0_w = x0_sh; x_fp_w = x_fp_sh; x_s_w = x_s_sh; x1_w = x1_sh;
    y0_w = y0_sh; y_fp_w = y_fp_sh; y_s_w = y_s_sh; y1_w = y1_sh;
`else
    x0_w = x0; x_fp_w = x_fp; x_s_w = x_s; x1_w = x1;
    y0_w = y0; y_fp_w = y_fp; y_s_w = y_s; y1_w = y1;
`endif
    if (cfg_we) begin
      case (cfg_sel)
        3'd0: x0_w   = $signed(cfg_data);
        3'd1: x_fp_w = $signed(cfg_data);
        3'd2: x_s_w  = $signed(cfg_data);
        3'd3: x1_w   = $signed(cfg_data);
        3'd4: y0_w   = $signed(cfg_data[Y_BITS-1:0]);
        3'd5: y_fp_w = $signed(cfg_data[Y_BITS-1:0]);
        3'd6: y_s_w  = $signed(cfg_data[Y_BITS-1:0]);
        3'd7: y1_w   = $signed(cfg_data[Y_BITS-1:0]);
        default: ;
      endcase
    end
  end

  // A >= test instead of == lets the counter recover on the next enabled
  // edge after x1/y1 is moved below the current count.
  assign last_x    = (x >= x1);
  assign last_y    = (y >= y1);
  assign line_end  = enable && last_x;
  assign frame_end = line_end && last_y;

  assign active = !x[X_BITS-1] && (x < x_fp) && !y[Y_BITS-1] && (y < y_fp);
  assign hsync  = (x >= x_s) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync  = (y >= y_s) ? VSYNC_POL : ~VSYNC_POL;

  always_ff @(posedge clk) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      x0   <= R_X0;   x_fp <= R_X_FP; x_s <= R_X_S; x1 <= R_X1;
      y0   <= R_Y0;   y_fp <= R_Y_FP; y_s <= R_Y_S; y1 <= R_Y1;
    end else begin
      // The wrap uses the current x0/y0, before any register update on this edge.
      if (enable) begin
        if (last_x) begin
          x <= x0;
          y <= last_y ? y0 : y + Y_ONE;
        end else begin
          x <= x + X_ONE;
        end
      end
`ifdef RASTER_SHADOW_EN
      if (frame_end) begin
`else
      begin
`endif
        x0 <= x0_w; x_fp <= x_fp_w; x_s <= x_s_w; x1 <= x1_w;
        y0 <= y0_w; y_fp <= y_fp_w; y_s <= y_s_w; y1 <= y1_w;
      end
    end
  end

`ifdef RASTER_SHADOW_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_sh <= R_X0; x_fp_sh <= R_X_FP; x_s_sh <= R_X_S; x1_sh <= R_X1;
      y0_sh <= R_Y0; y_fp_sh <= R_Y_FP; y_s_sh <= R_Y_S; y1_sh <= R_Y1;
    end else begin
      x0_sh <= x0_w; x_fp_sh <= x_fp_w; x_s_sh <= x_s_w; x1_sh <= x1_w;
      y0_sh <= y0_w; y_fp_sh <= y_fp_w; y_s_sh <= y_s_w; y1_sh <= y1_w;
    end
  end
`endif

endmodule

// File: tb/tb_raster_timing_gen.sv
// tb/tb_raster_timing_gen.sv - randomized self-checking bench for raster_timing_gen
module tb_raster_timing_gen;
  localparam int XB = 11;
  localparam int YB = 10;
  localparam int RSTV[8]  = '{-48, 640, 656, 752, -33, 480, 490, 492};
  localparam int SMALL[8] = '{-2, 4, 5, 6, -1, 2, 3, 3};

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, cfg_we = 1'b0;
  logic [2:0] cfg_sel = '0;
  logic [XB-1:0] cfg_data = '0;
  logic signed [XB-1:0] x, x_n;
  logic signed [YB-1:0] y, y_n;
  logic active, hsync, vsync, line_end, frame_end;
  logic active_n, hsync_n, vsync_n, line_end_n, frame_end_n;

  always #5 clk = ~clk;

  raster_timing_gen u_pos (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .x(x), .y(y), .active(active), .hsync(hsync), .vsync(vsync),
    .line_end(line_end), .frame_end(frame_end));

  raster_timing_gen #(.HSYNC_POL(1'b0), .VSYNC_POL(1'b0)) u_neg (
    .clk(clk), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .x(x_n), .y(y_n), .active(active_n), .hsync(hsync_n),
    .vsync(vsync_n), .line_end(line_end_n), .frame_end(frame_end_n));

  int total = 0;
  int bad = 0;

  // Reference: raster position as plain integers, timing as integer tables.
  int mx, my;
  int t[8];
  int s[8];
  bit chk_on = 1'b0;
  bit le_s, fe_s;
  int cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sx(input int v, input int w);
    return (v <<< (32 - w)) >>> (32 - w);
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit we, input int sel, input int data);
    bit fe;
    int wv;
    if (rst) begin
      mx = 0; my = 0;
      for (int i = 0; i < 8; i++) begin t[i] = RSTV[i]; s[i] = RSTV[i]; end
    end else begin
      fe = en && (mx >= t[3]) && (my >= t[7]);
      wv = (sel < 4) ? sx(data, XB) : sx(data, YB);
      if (en) begin
        if (mx >= t[3]) begin
          mx = t[0];
          my = (my >= t[7]) ? t[4] : my + 1;
        end else begin
          mx = mx + 1;
        end
      end
`ifdef RASTER_SHADOW_EN
      if (we) s[sel] = wv;
      if (fe) for (int i = 0; i < 8; i++) t[i] = s[i];
`else
      if (we) t[sel] = wv;
`endif
    end
  endtask

  task automatic tick(input bit rst, input bit en, input bit we, input int sel, input int data);
    int e_le, e_fe, e_act, e_hs, e_vs;
    reset = rst; enable = en; cfg_we = we; cfg_sel = 3'(sel); cfg_data = XB'(data);
    #1;
    e_le  = (en && mx >= t[3]) ? 1 : 0;
    e_fe  = (e_le == 1 && my >= t[7]) ? 1 : 0;
    e_act = (mx >= 0 && mx < t[1] && my >= 0 && my < t[5]) ? 1 : 0;
    e_hs  = (mx >= t[2]) ? 1 : 0;
    e_vs  = (my >= t[6]) ? 1 : 0;
    if (chk_on) begin
      check("x", int'(x), mx);
      check("y", int'(y), my);
      check("active", int'(active), e_act);
      check("hsync", int'(hsync), e_hs);
      check("vsync", int'(vsync), e_vs);
      check("line_end", int'(line_end), e_le);
      check("frame_end", int'(frame_end), e_fe);
      check("hsync_neg", int'(hsync_n), 1 - e_hs);
      check("vsync_neg", int'(vsync_n), 1 - e_vs);
      check("x_neg", int'(x_n), mx);
      check("active_neg", int'(active_n), e_act);
      check("frame_end_neg", int'(frame_end_n), e_fe);
    end
    le_s = line_end;
    fe_s = frame_end;
    @(posedge clk);
    model_step(rst, en, we, sel, data);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int last_fe, last_le, found;
    bit en;

    tick(1, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);

    reset = 1'b0; enable = 1'b1; cfg_we = 1'b0;
    #1;
    check("rst_x", int'(x), 0);
    check("rst_y", int'(y), 0);
    check("rst_active", int'(active), 1);
    check("rst_hsync", int'(hsync), 0);
    check("rst_vsync", int'(vsync), 0);
    check("rst_hsync_neg", int'(hsync_n), 1);
    check("rst_line_end", int'(line_end), 0);
    check("rst_frame_end", int'(frame_end), 0);
    chk_on = 1'b1;

    for (int i = 0; i < 8; i++) tick(0, 0, 1, i, SMALL[i]);
`ifdef RASTER_SHADOW_EN
    for (int i = 0; i < 500000 && t[3] != SMALL[3]; i++) tick(0, 1, 0, 0, 0);
    check("shadow_load", t[3], SMALL[3]);
`endif

    last_fe = -1; last_le = -1;
    for (int i = 0; i < 100; i++) begin
      tick(0, 1, 0, 0, 0);
      if (le_s) begin
        if (last_le >= 0) check("line_period", cyc - last_le, 9);
        last_le = cyc;
      end
      if (fe_s) begin
        if (last_fe >= 0) check("frame_period", cyc - last_fe, 45);
        last_fe = cyc;
      end
    end

    last_fe = -1;
    for (int i = 0; i < 200; i++) begin
      tick(0, (i % 2) == 0, 0, 0, 0);
      if (fe_s) begin
        if (last_fe >= 0) check("frame_period_gated", cyc - last_fe, 90);
        last_fe = cyc;
      end
    end

    for (int i = 0; i < 150; i++) tick(0, $urandom_range(0, 1) == 1, 0, 0, 0);

`ifndef RASTER_SHADOW_EN
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      if (mx == 6) found = 1;
      else tick(0, 1, 0, 0, 0);
    end
    check("wrap_reach", found, 1);
    tick(0, 0, 1, 3, 3);
    tick(0, 1, 0, 0, 0);
    check("wrap_line_end", int'(le_s), 1);
    check("wrap_x", int'(x), -2);
    tick(0, 0, 1, 3, 6);
`endif

    for (int i = 0; i < 300; i++) begin
      int sel, data;
      sel  = $urandom_range(0, 7);
      data = (sel < 4) ? int'($urandom_range(0, 40)) - 20 : int'($urandom_range(0, 20)) - 10;
      en   = $urandom_range(0, 3) != 0;
      tick(0, en, $urandom_range(0, 3) == 0, sel, data);
    end

    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    #1;
    check("midrst_x", int'(x), 0);
    check("midrst_y", int'(y), 0);
    check("midrst_active", int'(active), 1);
    tick(0, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
